// File: rtl/load_resp_unit_pkg.sv
// load_resp_unit_pkg: load type encoding, bus size codes and load FSM states
package load_resp_unit_pkg;
  typedef struct packed {
    logic       read_mem;
    logic       sign;
    logic [1:0] size;
  } load_type_t;
  localparam logic [1:0] LOADTYPE_LW = 2'b00;
  localparam logic [1:0] LOADTYPE_LH = 2'b01;
  localparam logic [1:0] LOADTYPE_LB = 2'b10;
  localparam logic [1:0] SRAM_SIZE_B = 2'd0;
  localparam logic [1:0] SRAM_SIZE_H = 2'd1;
  localparam logic [1:0] SRAM_SIZE_W = 2'd2;
  typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DISCARD, ST_HOLD} load_state_t;
  // Map a load size onto the bus size code; unknown sizes fall back to word.
  function automatic logic [1:0] bus_size(input logic [1:0] size);
    return size == LOADTYPE_LB ? SRAM_SIZE_B : size == LOADTYPE_LH ? SRAM_SIZE_H : SRAM_SIZE_W;
  endfunction
endpackage

// File: rtl/load_resp_unit_formatter.sv
// load_formatter: extract byte/half/word lane from a read word and sign- or zero-extend it
module load_formatter
  import load_resp_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  load_type_t  load_type,
  output logic [31:0] data
);
  logic [31:0] shifted;
  logic [7:0]  b;
  logic [15:0] h;
  // Select the addressed lane and extend it to a full word.
  always_comb begin
    shifted = rdata >> {addr, 3'b000};
    b = shifted[7:0];
    h = addr[1] ? rdata[31:16] : rdata[15:0];
    data = load_type.size == LOADTYPE_LB ? {{24{load_type.sign & b[7]}}, b} :
           load_type.size == LOADTYPE_LH ? {{16{load_type.sign & h[15]}}, h} : rdata;
  end
endmodule

// File: rtl/load_resp_unit.sv
// load_resp_unit: issue data-SRAM reads, format the response and hold it for writeback
module load_resp_unit
  import load_resp_unit_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic [AW-1:0] req_addr,
  input  load_type_t    req_loadtype,
  input  logic          flush,
  input  logic          wb_allow,
  output logic          data_req,
  output logic          data_wr,
  output logic [1:0]    data_size,
  output logic [AW-1:0] data_addr,
  input  logic          data_addr_ok,
  input  logic          data_data_ok,
  input  logic [DW-1:0] data_rdata,
  output logic          ld_valid,
  output logic [DW-1:0] ld_data,
  output logic          ld_addr_err,
  output logic          ld_stall
);
  load_state_t   state_q, state_d;
  logic [AW-1:0] addr_q;
  load_type_t    type_q;
  logic [DW-1:0] fmt_data;
  logic          misaligned, launch, capture;
  assign misaligned = (req_loadtype.size == LOADTYPE_LW && req_addr[1:0] != 2'b00) ||
                      (req_loadtype.size == LOADTYPE_LH && req_addr[0]);
  assign ld_addr_err = req_valid && req_loadtype.read_mem && misaligned;
  assign launch = state_q == ST_IDLE && req_valid && req_loadtype.read_mem && !misaligned && !flush;
  assign capture = state_q == ST_WAIT && data_data_ok && !flush;
  assign data_wr = 1'b0;
  assign data_req = state_q == ST_IDLE ? launch : state_q == ST_REQ && !flush;
  assign data_addr = state_q == ST_IDLE ? req_addr : addr_q;
  assign data_size = bus_size(state_q == ST_IDLE ? req_loadtype.size : type_q.size);
  assign ld_valid = state_q == ST_HOLD;
  assign ld_stall = launch || state_q == ST_REQ || state_q == ST_WAIT || state_q == ST_DISCARD ||
                    (state_q == ST_HOLD && !wb_allow);
  load_formatter u_fmt (
    .rdata    (data_rdata),
    .addr     (addr_q[1:0]),
    .load_type(type_q),
    .data     (fmt_data)
  );
  // State, request latches and the held result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      type_q  <= '0;
      ld_data <= '0;
    end else begin
      state_q <= state_d;
      if (launch) begin
        addr_q <= req_addr;
        type_q <= req_loadtype;
      end
      if (capture) ld_data <= fmt_data;
    end
  end
  // Next state: one outstanding load; a flushed in-flight response is drained in DISCARD.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (launch) state_d = data_addr_ok ? ST_WAIT : ST_REQ;
      ST_REQ:     state_d = flush ? ST_IDLE : data_addr_ok ? ST_WAIT : ST_REQ;
      ST_WAIT:    state_d = data_data_ok ? (flush ? ST_IDLE : ST_HOLD) : flush ? ST_DISCARD : ST_WAIT;
      ST_DISCARD: if (data_data_ok) state_d = ST_IDLE;
      ST_HOLD:    if (wb_allow || flush) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_load_resp_unit.sv
// tb_load_resp_unit: directed self-checking bench for load_resp_unit
module tb_load_resp_unit;
  import load_resp_unit_pkg::*;
  logic        clk, rst, req_valid, flush, wb_allow;
  logic [31:0] req_addr;
  load_type_t  req_loadtype;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_rdata, ld_data;
  logic        ld_valid, ld_addr_err, ld_stall;
  int vectors = 0;
  int miscompares = 0;

  load_resp_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_loadtype(req_loadtype), .flush(flush), .wb_allow(wb_allow),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_addr_err(ld_addr_err), .ld_stall(ld_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  function automatic load_type_t lt(input logic s, input logic [1:0] z);
    load_type_t t;
    t.read_mem = 1'b1;
    t.sign = s;
    t.size = z;
    return t;
  endfunction

  task automatic do_load(input string tag, input logic [31:0] a, input load_type_t t,
                         input logic [31:0] rd, input logic [31:0] exp, input logic [1:0] sz);
    cyc; req_valid = 1; req_addr = a; req_loadtype = t; data_addr_ok = 1; #1;
    chk({tag, ".req"}, {31'b0, data_req}, 1);
    chk({tag, ".size"}, {30'b0, data_size}, {30'b0, sz});
    chk({tag, ".addr"}, data_addr, a);
    chk({tag, ".stall0"}, {31'b0, ld_stall}, 1);
    cyc; req_valid = 0; data_addr_ok = 0; data_data_ok = 1; data_rdata = rd; #1;
    chk({tag, ".stall1"}, {31'b0, ld_stall}, 1);
    chk({tag, ".novalid"}, {31'b0, ld_valid}, 0);
    chk({tag, ".noreq"}, {31'b0, data_req}, 0);
    cyc; data_data_ok = 0; data_rdata = 0; wb_allow = 1; #1;
    chk({tag, ".valid"}, {31'b0, ld_valid}, 1);
    chk({tag, ".data"}, ld_data, exp);
    chk({tag, ".stall2"}, {31'b0, ld_stall}, 0);
    cyc; wb_allow = 0; #1;
    chk({tag, ".drop"}, {31'b0, ld_valid}, 0);
  endtask

  initial begin
    rst = 0; req_valid = 0; req_addr = 0; req_loadtype = '0; flush = 0; wb_allow = 0;
    data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
    #2;
    chk("rst.valid", {31'b0, ld_valid}, 0);
    chk("rst.data", ld_data, 0);
    chk("rst.req", {31'b0, data_req}, 0);
    chk("rst.stall", {31'b0, ld_stall}, 0);
    chk("rst.wr", {31'b0, data_wr}, 0);
    repeat (2) @(negedge clk);
    rst = 1;

    do_load("lw", 32'h0000_1004, lt(1, LOADTYPE_LW), 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'd2);
    do_load("lb", 32'h0000_1003, lt(1, LOADTYPE_LB), 32'h8012_3456, 32'hFFFF_FF80, 2'd0);
    do_load("lbu", 32'h0000_1003, lt(0, LOADTYPE_LB), 32'h8012_3456, 32'h0000_0080, 2'd0);
    do_load("lb0", 32'h0000_1000, lt(1, LOADTYPE_LB), 32'h8012_3456, 32'h0000_0056, 2'd0);
    do_load("lhu", 32'h0000_1002, lt(0, LOADTYPE_LH), 32'h9ABC_0000, 32'h0000_9ABC, 2'd1);
    do_load("lh", 32'h0000_1002, lt(1, LOADTYPE_LH), 32'h9ABC_0000, 32'hFFFF_9ABC, 2'd1);
    do_load("lh0", 32'h0000_1000, lt(1, LOADTYPE_LH), 32'h1234_8001, 32'hFFFF_8001, 2'd1);

    // misaligned half and word
    cyc; req_valid = 1; req_addr = 32'h0000_1001; req_loadtype = lt(1, LOADTYPE_LH); data_addr_ok = 1; #1;
    chk("mis_h.err", {31'b0, ld_addr_err}, 1);
    chk("mis_h.req", {31'b0, data_req}, 0);
    chk("mis_h.stall", {31'b0, ld_stall}, 0);
    cyc; req_addr = 32'h0000_1002; req_loadtype = lt(0, LOADTYPE_LW); #1;
    chk("mis_w.err", {31'b0, ld_addr_err}, 1);
    chk("mis_w.req", {31'b0, data_req}, 0);
    chk("mis_w.stall", {31'b0, ld_stall}, 0);
    cyc; req_valid = 0; data_addr_ok = 0; #1;
    chk("mis.idle_err", {31'b0, ld_addr_err}, 0);
    chk("mis.idle_req", {31'b0, data_req}, 0);
    chk("mis.idle_valid", {31'b0, ld_valid}, 0);

    // addr_ok withheld, flush in second REQ cycle
    cyc; req_valid = 1; req_addr = 32'h0000_2000; req_loadtype = lt(0, LOADTYPE_LW); #1;
    chk("req.launch", {31'b0, data_req}, 1);
    cyc; req_valid = 0; req_addr = 32'h0000_FFFF; #1;
    chk("req.hold1", {31'b0, data_req}, 1);
    chk("req.addr1", data_addr, 32'h0000_2000);
    chk("req.size1", {30'b0, data_size}, 2);
    chk("req.stall1", {31'b0, ld_stall}, 1);
    cyc; flush = 1; #1;
    chk("req.flush_req", {31'b0, data_req}, 0);
    cyc; flush = 0; #1;
    chk("req.idle_req", {31'b0, data_req}, 0);
    chk("req.idle_stall", {31'b0, ld_stall}, 0);
    chk("req.idle_valid", {31'b0, ld_valid}, 0);

    // REQ then addr_ok, halfword result
    cyc; req_valid = 1; req_addr = 32'h0000_2002; req_loadtype = lt(1, LOADTYPE_LH); #1;
    cyc; req_valid = 0; data_addr_ok = 1; #1;
    chk("req2.size", {30'b0, data_size}, 1);
    chk("req2.addr", data_addr, 32'h0000_2002);
    cyc; data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h7FFF_0000; #1;
    chk("req2.noreq", {31'b0, data_req}, 0);
    cyc; data_data_ok = 0; wb_allow = 1; #1;
    chk("req2.valid", {31'b0, ld_valid}, 1);
    chk("req2.data", ld_data, 32'h0000_7FFF);
    cyc; wb_allow = 0; #1;

    // flush in WAIT, response arrives two cycles later
    req_valid = 1; req_addr = 32'h0000_3000; req_loadtype = lt(0, LOADTYPE_LW); data_addr_ok = 1; #1;
    cyc; req_valid = 0; data_addr_ok = 0; flush = 1; #1;
    chk("disc.stall_w", {31'b0, ld_stall}, 1);
    cyc; flush = 0; req_valid = 1; req_addr = 32'h0000_3004; data_addr_ok = 1; #1;
    chk("disc.block_req", {31'b0, data_req}, 0);
    chk("disc.stall", {31'b0, ld_stall}, 1);
    chk("disc.novalid0", {31'b0, ld_valid}, 0);
    cyc; data_data_ok = 1; data_rdata = 32'hBAD0_BAD0; #1;
    chk("disc.block_req2", {31'b0, data_req}, 0);
    chk("disc.novalid1", {31'b0, ld_valid}, 0);
    cyc; data_data_ok = 0; data_rdata = 0; #1;
    chk("disc.novalid2", {31'b0, ld_valid}, 0);
    chk("disc.relaunch", {31'b0, data_req}, 1);
    chk("disc.reladdr", data_addr, 32'h0000_3004);
    cyc; req_valid = 0; data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h1234_5678; #1;
    cyc; data_data_ok = 0; wb_allow = 1; #1;
    chk("disc.valid", {31'b0, ld_valid}, 1);
    chk("disc.data", ld_data, 32'h1234_5678);
    cyc; wb_allow = 0; #1;

    // writeback back-pressure in HOLD
    req_valid = 1; req_addr = 32'h0000_4000; req_loadtype = lt(0, LOADTYPE_LW); data_addr_ok = 1; #1;
    cyc; req_valid = 0; data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'hCAFE_F00D; #1;
    cyc; data_data_ok = 0; data_rdata = 32'h0; #1;
    for (int i = 0; i < 4; i++) begin
      chk("hold.valid", {31'b0, ld_valid}, 1);
      chk("hold.data", ld_data, 32'hCAFE_F00D);
      chk("hold.stall", {31'b0, ld_stall}, 1);
      cyc;
    end
    wb_allow = 1; #1;
    chk("hold.release", {31'b0, ld_stall}, 0);
    chk("hold.last", {31'b0, ld_valid}, 1);
    cyc; wb_allow = 0; #1;
    chk("hold.gone", {31'b0, ld_valid}, 0);

    // async reset pulse mid-WAIT
    req_valid = 1; req_addr = 32'h0000_5000; req_loadtype = lt(0, LOADTYPE_LW); data_addr_ok = 1; #1;
    cyc; req_valid = 0; data_addr_ok = 0; #1;
    chk("arst.stall_w", {31'b0, ld_stall}, 1);
    #1 rst = 0; #1;
    chk("arst.stall", {31'b0, ld_stall}, 0);
    chk("arst.valid", {31'b0, ld_valid}, 0);
    chk("arst.data", ld_data, 0);
    chk("arst.req", {31'b0, data_req}, 0);
    repeat (2) @(negedge clk);
    rst = 1;
    cyc; #1;
    chk("arst.idle_stall", {31'b0, ld_stall}, 0);
    chk("arst.idle_valid", {31'b0, ld_valid}, 0);
    do_load("post", 32'h0000_6001, lt(1, LOADTYPE_LB), 32'h0000_FF00, 32'hFFFF_FFFF, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
